// File: rtl/pwm_pkg.sv
// Shared constants, types and the per-pin drive rule for the PWM peripheral.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int unsigned NUM_PINS = 16;

  typedef logic [NUM_PINS-1:0]  pin_vec_t;
  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

  // Enabled pins are either held high (static) or follow the shared PWM signal.
  function automatic logic pin_drive(input logic en, input logic pwm_en, input logic sig);
    return en & (~pwm_en | sig);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clock divider: tick is high for one clk every CLK_DIV clks.
module pwm_prescaler #(
  parameter int unsigned CLK_DIV = 3000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [15:0] div_cnt;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin static/PWM output stage with a shared 8-bit timebase and a duty
// register shadowed to period boundaries.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic     tick;
  logic     wrap;
  logic     pwm_sig;
  pwm_cnt_t pwm_cnt;
  pwm_cnt_t duty_sh;
  pin_vec_t en_out;
  pin_vec_t en_pwm;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign wrap   = tick & (pwm_cnt == '1);

  // Full-scale duty is forced high so the pwm_cnt == 255 tick has no low glitch.
  assign pwm_sig = (duty_sh == DUTY_FULL) | (pwm_cnt < duty_sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + PWM_CNT_W'(1);
    end
  end

  // Duty is only sampled at the period boundary so a mid-period write cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh      <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (wrap) begin
        duty_sh <= pwm_duty_cycle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PINS; i++) begin
        out[i] <= pin_drive(en_out[i], en_pwm[i], pwm_sig);
      end
    end
  end

endmodule
